// File: rtl/sq_ctrl_pkg.sv
// Shared types and helpers for the VDF squaring-iteration controller.
package sq_ctrl_pkg;

  localparam int SQ_NUM_ELEMENTS = 33;
  localparam int SQ_BIT_LEN      = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [SQ_BIT_LEN-1:0] elem_t;
  typedef elem_t operand_t [SQ_NUM_ELEMENTS];

  // A latency of 1 still needs a 1-bit register, so the width never drops to 0.
  function automatic int phase_width(input int latency);
    return (latency <= 1) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/sq_phase_counter.sv
// Modulo-PIPE_LATENCY phase counter; wrap marks phase 0, the issue/capture slot.
module sq_phase_counter
  import sq_ctrl_pkg::*;
#(
  parameter int PIPE_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic wrap
);

  localparam int PW = phase_width(PIPE_LATENCY);
  localparam logic [PW-1:0] LAST = PW'(PIPE_LATENCY - 1);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q + PW'(1);
    if (clr || phase_q == LAST) phase_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign wrap = (phase_q == '0);

endmodule

// File: rtl/sq_iter_ctrl.sv
// Runs T back-to-back squarings through the fixed-latency datapath, feeding each result back.
module sq_iter_ctrl
  import sq_ctrl_pkg::*;
#(
  parameter int NUM_ELEMENTS = 33,
  parameter int BIT_LEN      = 17,
  parameter int PIPE_LATENCY = 4,
  parameter int T_LEN        = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] start_sq_in,
  input  logic [T_LEN-1:0]                start_t,
  input  logic                            abort,
  output logic                            dp_load,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] dp_in,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] dp_out,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] result,
  output logic [T_LEN-1:0]                iter_count,
  output logic                            busy
);

  localparam int W = NUM_ELEMENTS * BIT_LEN;

  state_t           state_q, state_d;
  logic [W-1:0]     cur_q, cur_d;
  logic [W-1:0]     result_q, result_d;
  logic [T_LEN-1:0] rem_q, rem_d;
  logic [T_LEN-1:0] iter_q, iter_d;
  logic             first_q, first_d;
  logic             slot;

  // Phase is held at 0 outside RUN, so the first RUN cycle is always an issue slot.
  sq_phase_counter #(
    .PIPE_LATENCY(PIPE_LATENCY)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_RUN),
    .wrap  (slot)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    result_d = result_q;
    rem_d    = rem_q;
    iter_d   = iter_q;
    first_d  = first_q;
    dp_load  = 1'b0;
    dp_in    = cur_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          cur_d  = start_sq_in;
          rem_d  = start_t;
          iter_d = '0;
          if (start_t == '0) begin
            result_d = start_sq_in;
            state_d  = ST_DONE;
          end else begin
            first_d = 1'b1;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (slot && first_q) begin
          dp_load = 1'b1;
          first_d = 1'b0;
        end else if (slot) begin
          rem_d  = (rem_q != '0) ? rem_q - T_LEN'(1) : '0;
          iter_d = (iter_q != '1) ? iter_q + T_LEN'(1) : iter_q;
          if (rem_q <= T_LEN'(1)) begin
            result_d = dp_out;
            state_d  = ST_DONE;
          end else begin
            // Same-cycle bypass of the fresh result keeps the pipe full.
            dp_load = 1'b1;
            dp_in   = dp_out;
            cur_d   = dp_out;
          end
        end
      end

      ST_DONE: begin
        if (abort || result_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      iter_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      iter_q   <= iter_d;
      first_q  <= first_d;
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_RUN);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_sq_iter_ctrl.sv
// Directed bench for sq_iter_ctrl with a +1-on-element-0 delay-line datapath and a result scoreboard.
module tb_sq_iter_ctrl;

  localparam int N  = 33;
  localparam int B  = 17;
  localparam int L  = 4;
  localparam int TL = 64;
  localparam int W  = N * B;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic [W-1:0]  start_sq_in;
  logic [TL-1:0] start_t;
  logic          abort;
  logic          dp_load;
  logic [W-1:0]  dp_in;
  logic [W-1:0]  dp_out;
  logic          result_valid;
  logic          result_ready;
  logic [W-1:0]  result;
  logic [TL-1:0] iter_count;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc      = 0;

  typedef struct {
    logic [W-1:0] vec;
    logic [63:0]  iter;
    int           first_cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sq_iter_ctrl #(
    .NUM_ELEMENTS(N), .BIT_LEN(B), .PIPE_LATENCY(L), .T_LEN(TL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_sq_in  (start_sq_in),
    .start_t      (start_t),
    .abort        (abort),
    .dp_load      (dp_load),
    .dp_in        (dp_in),
    .dp_out       (dp_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .iter_count   (iter_count),
    .busy         (busy)
  );

  // Datapath model: L-stage delay line that increments element 0.
  logic [W-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= {dp_in[W-1:B], dp_in[B-1:0] + B'(1)};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_out = pipe[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got element0 %0h expected element0 %0h (full vector differs) at cycle %0d",
               name, act[B-1:0], exp[B-1:0], cyc);
    end
  endtask

  function automatic logic [W-1:0] mk_vec(input int el0);
    logic [W-1:0] v;
    for (int i = 1; i < N; i++) v[i*B +: B] = B'(i * 977 + 3);
    v[B-1:0] = B'(el0);
    return v;
  endfunction

  function automatic bit exp_load(input int rel, input int t);
    return (t > 0) && (rel >= 1) && (((rel - 1) % L) == 0) && (((rel - 1) / L) < t);
  endfunction

  // Monitor: samples 2 time units after the falling edge, after the stimulus has driven.
  logic         rv_prev = 1'b0;
  logic [W-1:0] held_res;
  logic [63:0]  held_iter;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        rv_prev = 1'b0;
      end else begin
        if (result_valid) begin
          if (!rv_prev) begin
            if (sb.size() == 0) check("result_valid with no job pending", result_valid, 0);
            else                check("first result_valid cycle", cyc, sb[0].first_cyc);
          end else begin
            check_vec("result hold", result, held_res);
            check("iter_count hold", iter_count, held_iter);
          end
          held_res  = result;
          held_iter = iter_count;
          if (result_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check_vec("result", result, e.vec);
            check("iter_count", iter_count, e.iter);
          end
        end
        rv_prev = result_valid;
      end
    end
  end

  // Drives a command on the current low phase; accepted at the next rising edge.
  task automatic start_job(input int t, input int el0, input bit expect_result);
    exp_t e;
    check("start_ready before start", start_ready, 1);
    start_valid = 1'b1;
    start_t     = TL'(t);
    start_sq_in = mk_vec(el0);
    acc         = cyc;
    if (expect_result) begin
      e.vec       = mk_vec(el0 + t);
      e.iter      = 64'(t);
      e.first_cyc = acc + ((t == 0) ? 1 : 2 + t * L);
      sb.push_back(e);
    end
  endtask

  task automatic run_job(input int t, input int el0, input int hold);
    int done_rel;
    done_rel     = (t == 0) ? 1 : 2 + t * L;
    result_ready = (hold == 0);
    start_job(t, el0, 1'b1);
    for (int rel = 1; rel <= done_rel + hold + 1; rel++) begin
      @(negedge clk);
      if (rel == 1) start_valid = 1'b0;
      check("dp_load", dp_load, exp_load(rel, t));
      if (exp_load(rel, t)) check("dp_in element0", dp_in[B-1:0], B'(el0 + (rel - 1) / L));
      check("busy", busy, (t > 0) && (rel <= 1 + t * L));
      check("start_ready", start_ready, rel > done_rel + hold);
      if (rel == done_rel + hold) result_ready = 1'b1;
    end
  endtask

  initial begin
    reset        = 1'b1;
    start_valid  = 1'b0;
    start_sq_in  = '0;
    start_t      = '0;
    abort        = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset start_ready", start_ready, 1);
    check("reset busy", busy, 0);
    check("reset result_valid", result_valid, 0);
    check("reset dp_load", dp_load, 0);
    check("reset iter_count", iter_count, 0);
    check_vec("reset result", result, '0);

    run_job(1, 5, 0);
    run_job(3, 5, 0);
    run_job(0, 7, 0);
    run_job(2, 5, 10);

    // Abort during cycle 7 of a t=5 job: no result, idle at cycle 8.
    result_ready = 1'b1;
    start_job(5, 5, 1'b0);
    for (int rel = 1; rel <= 8; rel++) begin
      @(negedge clk);
      if (rel == 1) start_valid = 1'b0;
      if (rel <= 6) begin
        check("abort job dp_load", dp_load, exp_load(rel, 5));
        check("abort job busy", busy, 1);
      end
      if (rel == 7) begin
        abort = 1'b1;
        #1;
        check("dp_load in abort cycle", dp_load, 0);
      end
      if (rel == 8) begin
        abort = 1'b0;
        check("start_ready after abort", start_ready, 1);
        check("busy after abort", busy, 0);
        check("result_valid after abort", result_valid, 0);
      end
    end
    run_job(1, 5, 0);

    // Synchronous reset during cycle 6 of a t=5 job.
    start_job(5, 5, 1'b0);
    for (int rel = 1; rel <= 7; rel++) begin
      @(negedge clk);
      if (rel == 1) start_valid = 1'b0;
      if (rel <= 5) check("pre-reset dp_load", dp_load, exp_load(rel, 5));
      if (rel == 6) begin
        check("iter_count before reset", iter_count, 1);
        reset = 1'b1;
      end
      if (rel == 7) begin
        check("mid-job reset start_ready", start_ready, 1);
        check("mid-job reset busy", busy, 0);
        check("mid-job reset result_valid", result_valid, 0);
        check("mid-job reset dp_load", dp_load, 0);
        check("mid-job reset iter_count", iter_count, 0);
        check_vec("mid-job reset result", result, '0);
        reset = 1'b0;
      end
    end
    run_job(1, 9, 0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
